stream_minmax_nch: RTL and testbench
====================================

// Module: stream_minmax_nch
// PURPOSE
//  Streaming multi-channel signed min/max tracker for the audio path.
//  Accepts channel-interleaved samples over a valid/ready handshake and
//  tracks running min/max per channel across a runtime-set frame length.
//  Reports per-channel results with a one-cycle done pulse.
//  Feeds the normalisation/gain stage after the audio sample source.
// PARAMETERS
//  WIDTH    16    sample width, two's-complement signed
//  NUM_CH   2     channels, interleaved ch0,ch1,..,ch(NUM_CH-1) per sample slot
//  MAX_LEN  1024  maximum samples per channel in one frame
//  LEN_W    $clog2(MAX_LEN+1)  width of frame_len and index outputs
// PORTS
//  clk        in   1             clock
//  reset      in   1             synchronous, active-high reset
//  start      in   1             begin frame; sampled in IDLE only
//  frame_len  in   LEN_W         samples per channel; sampled with start
//  s_valid    in   1             input sample valid
//  s_ready    out  1             input ready; high only in RUN
//  s_data     in   WIDTH         signed sample
//  busy       out  1             high in RUN
//  done       out  1             one-cycle pulse, results valid
//  err        out  1             one-cycle pulse, illegal frame_len
//  res_min    out  NUM_CH*WIDTH  packed per-channel min; ch k at [k*WIDTH +: WIDTH]
//  res_max    out  NUM_CH*WIDTH  packed per-channel max, same packing
// BEHAVIOUR
//  - Reset: state IDLE; s_ready=0, busy=0, done=0, err=0; every res_min lane is the
//    most-positive value (0x7FFF at WIDTH=16); every res_max lane is the most-negative value (0x8000).
//  - Beat = cycle with s_valid && s_ready. Only beats update state.
//  - FSM: IDLE -> RUN -> DONE -> IDLE.
//  - IDLE, start=1, 1<=frame_len<=MAX_LEN:
//    - Latch frame_len.
//    - Set all min lanes to most-positive and all max lanes to most-negative.
//    - Clear ch_cnt and smp_cnt.
//    - Go to RUN next cycle.
//  - IDLE, start=1, frame_len==0 or >MAX_LEN: err=1 for one cycle; stay IDLE; results untouched.
//  - RUN: s_ready=1, busy=1. start is ignored. Each beat:
//    - Signed compare s_data against lane ch_cnt.
//    - Strict < updates min; strict > updates max. Ties keep the earlier value.
//    - ch_cnt wraps NUM_CH-1 -> 0; smp_cnt increments on the wrap.
//  - Final beat (ch_cnt==NUM_CH-1 && smp_cnt==frame_len-1): result lanes update in that
//    same cycle; state moves to DONE.
//  - DONE: done=1 for exactly one cycle, s_ready=0, busy=0; then IDLE.
//    done is high the cycle after the final beat.
//  - Results hold stable from DONE until the next legal start.
//  - Gaps (s_valid=0) in RUN: hold all counters and lanes; no timeout.
//  - Reset mid-frame: abort immediately; all outputs return to reset values; no done.
//  - Throughput: one sample per cycle. Frame duration = NUM_CH*frame_len beats + 1 cycle.
// CONFIGURATION
//  - MINMAX_INDEX_EN defined: adds the following outputs.
//    - res_min_idx  out  NUM_CH*LEN_W  per channel, smp_cnt of the first occurrence of the min
//    - res_max_idx  out  NUM_CH*LEN_W  same, for the max
//    - Both reset to 0. Both clear to 0 on a legal start. Both update with their value lane.
//  - MINMAX_INDEX_EN undefined: these ports and their registers do not exist; all
//    other behaviour is identical.
// TESTING  (WIDTH=16, NUM_CH=2, MAX_LEN=8)
//  1. frame_len=3; stream 5,-32768,-3,0,7,32767 ->
//     res_min={ch1:-32768, ch0:-3}, res_max={ch1:32767, ch0:7}.
//     done exactly 1 cycle after the 6th beat.
//  2. Same data with s_valid low on alternate cycles ->
//     identical results; done 1 cycle after the last beat.
//  3. frame_len=0, then frame_len=9 -> err pulse each time; busy stays 0; results unchanged.
//  4. frame_len=4; reset after 3 beats; new frame_len=1 with ch0=-1, ch1=2 ->
//     res_min={2,-1}, res_max={2,-1}; no done pulse for the aborted frame.
//  5. start pulsed during RUN -> ignored; frame completes on the original frame_len.
//  6. MINMAX_INDEX_EN: frame_len=4, ch0=3,1,1,9 ->
//     min0=1 with idx 1 (first tie kept), max0=9 with idx 3.

Source files
------------

// File: rtl/stream_minmax_nch.sv
// -----------------------------------------------------------------------------
// stream_minmax_nch
//   Streaming multi-channel signed min/max tracker for the audio path.
//   Channel-interleaved samples (ch0, ch1, .., ch(NUM_CH-1) per slot) arrive
//   over a valid/ready handshake. Running min/max is kept per channel over a
//   frame of frame_len slots. The results are reported with a one-cycle done
//   pulse and then held until the next legal start.
//
//   Optional feature: define MINMAX_INDEX_EN to add per-channel index outputs.
//   Each index is the slot number of the first occurrence of the min or max.
//
// Ports
//   clk          in   clock
//   reset        in   synchronous, active-high reset
//   start        in   begin frame (sampled in IDLE only)
//   frame_len    in   slots per frame, legal range 1..MAX_LEN (sampled with start)
//   s_valid      in   sample valid
//   s_ready      out  sample ready, high only while running
//   s_data       in   two's-complement sample
//   busy         out  high while running
//   done         out  one-cycle pulse; results are valid
//   err          out  one-cycle pulse; start with illegal frame_len
//   res_min      out  packed per-channel min, ch k at [k*WIDTH +: WIDTH]
//   res_max      out  packed per-channel max, same packing
//   res_min_idx  out  (MINMAX_INDEX_EN) packed per-channel index of the min
//   res_max_idx  out  (MINMAX_INDEX_EN) packed per-channel index of the max
// -----------------------------------------------------------------------------
module stream_minmax_nch #(
  parameter int WIDTH   = 16,
  parameter int NUM_CH  = 2,
  parameter int MAX_LEN = 1024,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [LEN_W-1:0]        frame_len,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [WIDTH-1:0]        s_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [NUM_CH*WIDTH-1:0] res_min,
  output logic [NUM_CH*WIDTH-1:0] res_max
`ifdef MINMAX_INDEX_EN
  ,
  output logic [NUM_CH*LEN_W-1:0] res_min_idx,
  output logic [NUM_CH*LEN_W-1:0] res_max_idx
`endif
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic signed [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CH_W-1:0]         LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [LEN_W-1:0]        LEN_MAX  = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [LEN_W-1:0]        len_q;
  logic [CH_W-1:0]         ch_cnt;
  logic [LEN_W-1:0]        smp_cnt;
  logic signed [WIDTH-1:0] min_lane [NUM_CH];
  logic signed [WIDTH-1:0] max_lane [NUM_CH];
`ifdef MINMAX_INDEX_EN
  logic [LEN_W-1:0]        min_idx  [NUM_CH];
  logic [LEN_W-1:0]        max_idx  [NUM_CH];
`endif

  logic                    beat;
  logic                    len_ok;
  logic                    last_slot;
  logic                    last_beat;
  logic signed [WIDTH-1:0] sample;
  logic signed [WIDTH-1:0] cur_min;
  logic signed [WIDTH-1:0] cur_max;
  logic                    take_min;
  logic                    take_max;

  assign sample    = s_data;
  assign beat      = s_valid && s_ready;
  assign len_ok    = (frame_len != '0) && (frame_len <= LEN_MAX);
  assign last_slot = (smp_cnt == (len_q - LEN_W'(1)));
  assign last_beat = beat && (ch_cnt == LAST_CH) && last_slot;

  // Lane selected by the channel counter. Strict compares keep the earliest
  // of equal values, which is also what makes the index "first occurrence".
  assign cur_min  = min_lane[ch_cnt];
  assign cur_max  = max_lane[ch_cnt];
  assign take_min = (sample < cur_min);
  assign take_max = (sample > cur_max);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      s_ready <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      len_q   <= '0;
      ch_cnt  <= '0;
      smp_cnt <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        min_lane[k] <= MOST_POS;
        max_lane[k] <= MOST_NEG;
`ifdef MINMAX_INDEX_EN
        min_idx[k]  <= '0;
        max_idx[k]  <= '0;
`endif
      end
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (len_ok) begin
              len_q   <= frame_len;
              ch_cnt  <= '0;
              smp_cnt <= '0;
              for (int k = 0; k < NUM_CH; k++) begin
                min_lane[k] <= MOST_POS;
                max_lane[k] <= MOST_NEG;
`ifdef MINMAX_INDEX_EN
                min_idx[k]  <= '0;
                max_idx[k]  <= '0;
`endif
              end
              state   <= ST_RUN;
              s_ready <= 1'b1;
              busy    <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (beat) begin
            if (take_min) begin
              min_lane[ch_cnt] <= sample;
`ifdef MINMAX_INDEX_EN
              min_idx[ch_cnt]  <= smp_cnt;
`endif
            end
            if (take_max) begin
              max_lane[ch_cnt] <= sample;
`ifdef MINMAX_INDEX_EN
              max_idx[ch_cnt]  <= smp_cnt;
`endif
            end
            if (ch_cnt == LAST_CH) begin
              ch_cnt  <= '0;
              smp_cnt <= smp_cnt + LEN_W'(1);
            end else begin
              ch_cnt  <= ch_cnt + CH_W'(1);
            end
            if (last_beat) begin
              state   <= ST_DONE;
              s_ready <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state   <= ST_IDLE;
          s_ready <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign res_min[g*WIDTH +: WIDTH] = min_lane[g];
    assign res_max[g*WIDTH +: WIDTH] = max_lane[g];
`ifdef MINMAX_INDEX_EN
    assign res_min_idx[g*LEN_W +: LEN_W] = min_idx[g];
    assign res_max_idx[g*LEN_W +: LEN_W] = max_idx[g];
`endif
  end

endmodule

// File: tb/tb_stream_minmax_nch.sv
// -----------------------------------------------------------------------------
// tb_stream_minmax_nch
//   Self-checking bench for stream_minmax_nch at WIDTH=16, NUM_CH=2, MAX_LEN=8.
//   Expected results come from a behavioural model that scans the frame's
//   sample list per channel and keeps the held result between frames.
// -----------------------------------------------------------------------------
module tb_stream_minmax_nch;

  localparam int WIDTH   = 16;
  localparam int NUM_CH  = 2;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int POS_V   = (1 << (WIDTH - 1)) - 1;
  localparam int NEG_V   = -(1 << (WIDTH - 1));

  logic                    clk;
  logic                    reset;
  logic                    start;
  logic [LEN_W-1:0]        frame_len;
  logic                    s_valid;
  logic                    s_ready;
  logic [WIDTH-1:0]        s_data;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic [NUM_CH*WIDTH-1:0] res_min;
  logic [NUM_CH*WIDTH-1:0] res_max;
`ifdef MINMAX_INDEX_EN
  logic [NUM_CH*LEN_W-1:0] res_min_idx;
  logic [NUM_CH*LEN_W-1:0] res_max_idx;
`endif

  stream_minmax_nch #(
    .WIDTH  (WIDTH),
    .NUM_CH (NUM_CH),
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .frame_len  (frame_len),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .res_min    (res_min),
    .res_max    (res_max)
`ifdef MINMAX_INDEX_EN
    ,
    .res_min_idx(res_min_idx),
    .res_max_idx(res_max_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  int data_q [$];
  int exp_min [NUM_CH];
  int exp_max [NUM_CH];
  int exp_min_i [NUM_CH];
  int exp_max_i [NUM_CH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      exp_min[c] = POS_V;  exp_max[c] = NEG_V;
      exp_min_i[c] = 0;    exp_max_i[c] = 0;
    end
  endtask

  // Per channel: scan slots in order, keep the first strict extreme.
  task automatic model_frame(input int len);
    model_reset();
    for (int c = 0; c < NUM_CH; c++)
      for (int s = 0; s < len; s++) begin
        int v;
        v = data_q[s*NUM_CH + c];
        if (v < exp_min[c]) begin exp_min[c] = v; exp_min_i[c] = s; end
        if (v > exp_max[c]) begin exp_max[c] = v; exp_max_i[c] = s; end
      end
  endtask

  function automatic logic [NUM_CH*WIDTH-1:0] pack_val(input int a [NUM_CH]);
    logic [NUM_CH*WIDTH-1:0] p;
    for (int c = 0; c < NUM_CH; c++) p[c*WIDTH +: WIDTH] = WIDTH'(a[c]);
    return p;
  endfunction

  function automatic logic [NUM_CH*LEN_W-1:0] pack_idx(input int a [NUM_CH]);
    logic [NUM_CH*LEN_W-1:0] p;
    for (int c = 0; c < NUM_CH; c++) p[c*LEN_W +: LEN_W] = LEN_W'(a[c]);
    return p;
  endfunction

  task automatic chk_results(input string tag);
    chk({tag, "_min"}, 64'(res_min), 64'(pack_val(exp_min)));
    chk({tag, "_max"}, 64'(res_max), 64'(pack_val(exp_max)));
`ifdef MINMAX_INDEX_EN
    chk({tag, "_min_idx"}, 64'(res_min_idx), 64'(pack_idx(exp_min_i)));
    chk({tag, "_max_idx"}, 64'(res_max_idx), 64'(pack_idx(exp_max_i)));
`endif
  endtask

  // gap_mode: 0 = back-to-back, 1 = valid on alternate cycles, 2 = random gaps.
  // poke_start pulses start (with a short frame_len) in the middle of the frame.
  task automatic run_frame(input string tag, input int len, input int gap_mode, input bit poke_start);
    int total, idx, cyc;
    bit v, alt, early;
    total = NUM_CH * len;
    idx = 0; cyc = 0; alt = 1'b1; early = 1'b0;
    @(negedge clk);
    start = 1'b1; frame_len = LEN_W'(len);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_run"}, 64'(busy), 64'd1);
    chk({tag, "_ready_run"}, 64'(s_ready), 64'd1);
    while (idx < total && cyc < 1000) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = alt;
        default: v = 1'($urandom_range(0, 1));
      endcase
      alt = ~alt;
      s_valid = v;
      s_data  = WIDTH'(data_q[idx]);
      if (poke_start && idx == 1) begin start = 1'b1; frame_len = LEN_W'(1); end
      else start = 1'b0;
      @(negedge clk);
      cyc++;
      if (v) idx++;
      if (idx < total && (done || !busy || !s_ready)) early = 1'b1;
    end
    s_valid = 1'b0; start = 1'b0;
    chk({tag, "_beats"}, 64'(idx), 64'(total));
    chk({tag, "_early_end"}, 64'(early), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy_done"}, 64'(busy), 64'd0);
    chk({tag, "_ready_done"}, 64'(s_ready), 64'd0);
    model_frame(len);
    chk_results(tag);
    @(negedge clk);
    chk({tag, "_done_width"}, 64'(done), 64'd0);
    chk_results({tag, "_hold"});
  endtask

  task automatic try_bad(input string tag, input int len);
    @(negedge clk);
    start = 1'b1; frame_len = LEN_W'(len);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_err"}, 64'(err), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_ready"}, 64'(s_ready), 64'd0);
    @(negedge clk);
    chk({tag, "_err_width"}, 64'(err), 64'd0);
    chk({tag, "_busy2"}, 64'(busy), 64'd0);
    chk_results(tag);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, 64'(s_ready), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    model_reset();
    chk_results(tag);
  endtask

  function automatic int rand_sample();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return NEG_V;
    if (r == 1) return POS_V;
    if (r == 2) return int'($urandom_range(0, 6)) - 3;
    return int'($urandom_range(0, 65535)) + NEG_V;
  endfunction

  initial begin
    bit aborted_done;
    reset = 1'b1; start = 1'b0; frame_len = '0; s_valid = 1'b0; s_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_reset_state("rst");

    // 1: directed frame, back-to-back
    data_q = '{5, -32768, -3, 0, 7, 32767};
    run_frame("t1", 3, 0, 1'b0);
    chk("t1_min_const", 64'(res_min), 64'h8000_fffd);
    chk("t1_max_const", 64'(res_max), 64'h7fff_0007);

    // 2: same data with alternate-cycle gaps
    run_frame("t2", 3, 1, 1'b0);

    // 3: illegal lengths
    try_bad("t3_len0", 0);
    try_bad("t3_len9", 9);
    try_bad("t3_len15", 15);

    // 4: reset mid-frame, then a one-slot frame
    data_q = '{10, 20, 30, 40, 50, 60, 70, 80};
    aborted_done = 1'b0;
    @(negedge clk);
    start = 1'b1; frame_len = LEN_W'(4);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = WIDTH'(data_q[i]);
      @(negedge clk);
      if (done) aborted_done = 1'b1;
    end
    s_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    if (done) aborted_done = 1'b1;
    chk_reset_state("t4_abort");
    repeat (3) begin
      @(negedge clk);
      if (done) aborted_done = 1'b1;
    end
    chk("t4_no_done", 64'(aborted_done), 64'd0);
    data_q = '{-1, 2};
    run_frame("t4", 1, 0, 1'b0);
    chk("t4_min_const", 64'(res_min), 64'h0002_ffff);
    chk("t4_max_const", 64'(res_max), 64'h0002_ffff);

    // 5: start pulsed during RUN is ignored
    data_q = {};
    for (int i = 0; i < NUM_CH*5; i++) data_q.push_back(rand_sample());
    run_frame("t5", 5, 2, 1'b1);

`ifdef MINMAX_INDEX_EN
    // 6: index of first occurrence
    data_q = '{3, 0, 1, 0, 1, 0, 9, 0};
    run_frame("t6", 4, 0, 1'b0);
    chk("t6_min0_idx", 64'(res_min_idx[LEN_W-1:0]), 64'd1);
    chk("t6_max0_idx", 64'(res_max_idx[LEN_W-1:0]), 64'd3);
`endif

    // 7: randomized frames, including lengths 1 and MAX_LEN and repeated values
    for (int f = 0; f < 24; f++) begin
      int len;
      len = (f == 0) ? 1 : (f == 1) ? MAX_LEN : int'($urandom_range(1, MAX_LEN));
      data_q = {};
      for (int i = 0; i < NUM_CH*len; i++)
        data_q.push_back((f % 4 == 3) ? int'($urandom_range(0, 2)) - 1 : rand_sample());
      run_frame("rnd", len, f % 3, (f % 5 == 4) && len > 1);
      if (f % 7 == 6) try_bad("rnd_bad", 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
